// File: rtl/dsubbytes_iter.sv
// Iterative AES InvSubBytes engine: COLS_PER_BEAT 32-bit columns of the state per cycle,
// with valid/ready on both sides. dsoftbox is the combinational inverse S-box lane.

module dsoftbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      acc = b[i] ? (acc ^ aa) : acc;
      aa  = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0 naturally).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  logic [7:0] w_pre;

  // Inverse affine transform followed by the field inverse.
  always_comb begin
    w_pre  = {i_byte[6:0], i_byte[7]} ^ {i_byte[4:0], i_byte[7:5]} ^
             {i_byte[1:0], i_byte[7:2]} ^ 8'h05;
    o_byte = gf_inv(w_pre);
  end

endmodule

module dsubbytes_iter #(
  parameter int COLS_PER_BEAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int BEATS = 4 / COLS_PER_BEAT;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GW    = 32 * COLS_PER_BEAT;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [BW-1:0]   r_beat, w_beat_nxt;
  logic [127:0]    r_data, w_data_nxt;
  logic [GW-1:0]   w_grp_in, w_grp_out;

  // Column group addressed by the beat counter; group 0 sits at the MSBs.
  always_comb begin
    w_grp_in = {GW{1'b0}};
    for (int g = 0; g < BEATS; g++) begin
      w_grp_in = (r_beat == BW'(g)) ? r_data[127 - GW*g -: GW] : w_grp_in;
    end
  end

  for (genvar l = 0; l < 4*COLS_PER_BEAT; l++) begin : g_lane
    dsoftbox u_sbox (
      .i_byte (w_grp_in[GW-1-8*l -: 8]),
      .o_byte (w_grp_out[GW-1-8*l -: 8])
    );
  end

  // Handshake decode from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      S_DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Next state, beat counter and in-place column write-back; flush wins over everything.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_data_nxt  = r_data;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_beat_nxt  = {BW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            w_state_nxt = S_SUB;
            w_beat_nxt  = {BW{1'b0}};
            w_data_nxt  = in_data;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_SUB: begin
          for (int g = 0; g < BEATS; g++) begin
            w_data_nxt[127 - GW*g -: GW] = (r_beat == BW'(g)) ? w_grp_out
                                                              : r_data[127 - GW*g -: GW];
          end
          if (r_beat == LAST_BEAT) begin
            w_state_nxt = S_DONE;
          end else begin
            w_beat_nxt = r_beat + BW'(1);
          end
        end
        S_DONE: begin
          if (out_ready && in_valid) begin
            w_state_nxt = S_SUB;
            w_beat_nxt  = {BW{1'b0}};
            w_data_nxt  = in_data;
          end else if (out_ready) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_beat_nxt  = {BW{1'b0}};
        end
      endcase
    end
  end

  // State, beat counter and state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_beat  <= {BW{1'b0}};
      r_data  <= 128'h0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign out_data = r_data;

endmodule

// File: tb/tb_dsubbytes_iter.sv
// Self-checking bench for dsubbytes_iter (COLS_PER_BEAT=1): directed vectors plus a
// transaction-level model whose inverse S-box is built by inverting the forward S-box.

module tb_dsubbytes_iter;

  localparam int BEATS = 4;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         flush     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] in_data   = 128'h0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [127:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int in_hs_cnt = 0;
  int in_hs_cyc[$];
  logic [127:0] exp_q[$];
  logic [127:0] got_q[$];
  logic [7:0]   inv_tab[256];

  int           m_phase = 0;
  int           m_left  = 0;
  logic [127:0] m_exp   = 128'h0;

  dsubbytes_iter #(.COLS_PER_BEAT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Polynomial product followed by reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tab;
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] invsub(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[v[8*i +: 8]];
    return r;
  endfunction

  // Block-level model: a block accepted is busy for BEATS cycles, then offered until taken.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_left  <= 0;
    end else if (flush) begin
      m_phase <= 0;
    end else if (m_phase == 0) begin
      if (in_valid) begin
        m_phase <= 1;
        m_left  <= BEATS;
        m_exp   <= invsub(in_data);
      end
    end else if (m_phase == 1) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_phase <= 2;
    end else if (out_ready) begin
      exp_q.push_back(m_exp);
      if (in_valid) begin
        m_phase <= 1;
        m_left  <= BEATS;
        m_exp   <= invsub(in_data);
      end else begin
        m_phase <= 0;
      end
    end
  end

  // Per-cycle compare against the model, plus DUT-side handshake capture.
  always @(negedge clk) begin
    chk_b("busy", busy, m_phase != 0);
    if (!flush) begin
      chk_b("in_ready", in_ready, (m_phase == 0) || (m_phase == 2 && out_ready));
      chk_b("out_valid", out_valid, m_phase == 2);
    end
    if (m_phase == 2) chk_w("out_data", out_data, m_exp);
    if (rst_n && !flush && out_valid && out_ready) got_q.push_back(out_data);
    if (rst_n && !flush && in_valid && in_ready) begin
      in_hs_cnt++;
      in_hs_cyc.push_back(cyc);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid;
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk_b("valid_timeout", out_valid, 1'b1);
  endtask

  task automatic send(input logic [127:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    int bn;
    int start;
    logic [127:0] blk_a;
    logic [127:0] blk_b;
    logic [127:0] blk;

    build_tab();
    chk_w("tab_63", 128'(inv_tab[8'h63]), 128'h00);
    chk_w("tab_7c", 128'(inv_tab[8'h7c]), 128'h01);
    chk_w("tab_ff", 128'(inv_tab[8'hff]), 128'h7d);
    chk_w("tab_16", 128'(inv_tab[8'h16]), 128'hff);
    chk_w("tab_00", 128'(inv_tab[8'h00]), 128'h52);

    @(negedge clk);
    chk_b("rst_in_ready", in_ready, 1'b1);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_w("rst_out_data", out_data, 128'h0);
    #2 rst_n = 1'b1;
    tick();

    // Latency and busy duration.
    send({16{8'h63}});
    n  = 1;
    bn = 0;
    while (!out_valid && n < 20) begin
      if (busy) bn++;
      tick();
      n++;
    end
    chk_w("latency", 128'(n), 128'd5);
    chk_w("sbox63_data", out_data, 128'h0);
    while (busy && bn < 20) begin
      bn++;
      tick();
    end
    chk_w("busy_cycles", 128'(bn), 128'd5);

    // Column order.
    send(128'h00000000_7c7c7c7c_ffffffff_16161616);
    tick();
    tick();
    chk_w("mid_block", out_data, 128'h52525252_01010101_ffffffff_16161616);
    wait_valid();
    chk_w("col_order", out_data, 128'h52525252_01010101_7d7d7d7d_ffffffff);
    tick();

    // Back-pressure, then release while offering the next block.
    blk_a = 128'h0123456789abcdef_fedcba9876543210;
    blk_b = 128'h00112233445566778899aabbccddeeff;
    out_ready = 1'b0;
    send(blk_a);
    wait_valid();
    in_valid = 1'b1;
    in_data  = blk_b;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk_b("bp_in_ready", in_ready, 1'b0);
      chk_w("bp_stable", out_data, invsub(blk_a));
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk_b("bp_release_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_b("b2b_busy", busy, 1'b1);
    chk_b("b2b_no_valid", out_valid, 1'b0);
    wait_valid();
    chk_w("b2b_data", out_data, invsub(blk_b));
    tick();

    // Streaming with continuous input.
    in_hs_cyc.delete();
    for (int k = 0; k < 8; k++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      in_data  = blk;
      start = in_hs_cnt;
      n = 0;
      while (in_hs_cnt == start && n < 50) begin
        tick();
        n++;
      end
      chk_b("stream_accept", in_hs_cnt != start, 1'b1);
    end
    in_valid = 1'b0;
    wait_valid();
    tick();
    chk_w("stream_accepts", 128'(in_hs_cyc.size()), 128'd8);
    for (int i = 1; i < in_hs_cyc.size(); i++)
      chk_w("stream_interval", 128'(in_hs_cyc[i] - in_hs_cyc[i-1]), 128'(BEATS + 1));

    // Flush during the second SUB cycle.
    send(128'hdeadbeef_cafef00d_01020304_a5a5a5a5);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_b("flush_sub_valid", out_valid, 1'b0);
    chk_b("flush_sub_busy", busy, 1'b0);
    send(128'h11111111_22222222_33333333_44444444);
    wait_valid();
    chk_w("after_flush_data", out_data, invsub(128'h11111111_22222222_33333333_44444444));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_b("flush_done_valid", out_valid, 1'b0);
    chk_b("flush_done_busy", busy, 1'b0);
    send(128'h55555555_66666666_77777777_88888888);
    wait_valid();
    tick();

    // Asynchronous reset mid-SUB.
    send(128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_b("arst_in_ready", in_ready, 1'b1);
    chk_b("arst_out_valid", out_valid, 1'b0);
    chk_b("arst_busy", busy, 1'b0);
    chk_w("arst_out_data", out_data, 128'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    send(128'h0f0e0d0c_0b0a0908_07060504_03020100);
    wait_valid();
    chk_w("post_rst_data", out_data, invsub(128'h0f0e0d0c_0b0a0908_07060504_03020100));
    tick();
    tick();

    // In-order scoreboard of completed output handshakes.
    chk_w("out_count", 128'(got_q.size()), 128'(exp_q.size()));
    chk_w("out_count_abs", 128'(exp_q.size()), 128'd14);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk_w("scoreboard", got_q[i], exp_q[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dsubbytes_iter.md
# dsubbytes_iter

Iterative InvSubBytes engine for the AES decryption datapath. It applies the inverse S-box to a 128-bit state using `4*COLS_PER_BEAT` `dsoftbox` lookups, one or more 32-bit columns per cycle, instead of 16 lookups in parallel. It sits between the InvShiftRows and AddRoundKey stages of the decryption round sequencer. Both sides use valid/ready handshakes, and a finished block is held until the consumer takes it.

## Interface
- `COLS_PER_BEAT`, default 1: columns substituted per cycle. Legal values are 1, 2 and 4. `BEATS = 4/COLS_PER_BEAT`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `flush` input 1: synchronous abort. It discards the block in flight and returns to IDLE.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block can be accepted this cycle.
- `in_data` input 128: state in column-major order. Column 0 is `[127:96]` and the row-0 byte is in the MSB.
- `out_valid` output 1: `out_data` holds a completed InvSubBytes result.
- `out_ready` input 1: consumer accepts `out_data`.
- `out_data` output 128: substituted state, same byte layout as `in_data`.
- `busy` output 1: high in SUB or DONE.

## Operation
- Datapath:
  - One 128-bit state register.
  - Beat counter `beat`, ceil(log2(BEATS)) bits, minimum 1 bit.
  - `4*COLS_PER_BEAT` `dsoftbox` instances, all combinational.
- On beat `b`, columns `b*COLS_PER_BEAT` through `(b+1)*COLS_PER_BEAT-1` are read from the state register, passed through `dsoftbox`, and written back in place. All other columns are unchanged.
- Columns are processed in ascending order: column 0, `[127:96]`, first.
- State machine:
  - IDLE:
    - `in_ready=1`.
    - On `in_valid`, load `in_data`, set `beat=0`, go to SUB.
  - SUB:
    - Substitute the current column group.
    - If `beat==BEATS-1`, go to DONE. Otherwise increment `beat`.
    - `in_ready=0`.
  - DONE:
    - `out_valid=1`. `out_data` is the state register and must stay stable while `out_ready=0`.
    - On `out_ready`: if `in_valid`, load the new block, set `beat=0` and go to SUB (back-to-back). Otherwise go to IDLE.
    - `in_ready = out_ready` in this state.
- `flush` has priority over every handshake.
  - Next state is IDLE, `beat=0`, and the state register is left unchanged.
  - No handshake completes in a flush cycle. `in_ready` and `out_valid` are still driven from the current state, but the bench must ignore them.
- `out_data` is the state register in every state. It is don't-care unless `out_valid=1`.

## Timing
- Reset values: state=IDLE, `beat=0`, state register=0, `in_ready=1`, `out_valid=0`, `busy=0`, `out_data=128'h0`.
- Reset asserted mid-operation aborts immediately and asynchronously. No partial result is ever presented.
- Latency:
  - The accept edge is E0.
  - Substitution happens on edges E1..E_BEATS.
  - `out_valid` is high from edge E_BEATS+1's preceding cycle onward. Equivalently, with `COLS_PER_BEAT=1`, `out_valid` is first observed high in the cycle after the 4th SUB cycle, 5 cycles after the accept cycle.
- Throughput with `out_ready` held high and a continuous input:
  - One block per `BEATS+1` cycles: 5 for `COLS_PER_BEAT=1`, 2 for `COLS_PER_BEAT=4`.
- `in_ready` and `out_valid` are registered-state decodes, except the DONE-state term `in_ready=out_ready`, which is combinational.
- A simultaneous output handshake and input handshake in DONE is legal and loses no cycle.
- Back-pressure: DONE is held indefinitely. `out_data` must not change and `in_ready` stays 0 while `out_ready=0`.
- Beat counter:
  - With `BEATS=1`, `beat` is constant 0 and SUB lasts exactly one cycle.
  - `beat` never wraps inside a block. It is reloaded to 0 on every accept.

## Test plan
- Reset, then `in_data={16{8'h63}}` with `COLS_PER_BEAT=1` and `out_ready=1`:
  - `out_valid` rises 5 cycles after accept.
  - `out_data=128'h0`.
  - `busy` is high for exactly 5 cycles.
- Column-order check: `in_data=128'h00000000_7c7c7c7c_ffffffff_16161616`:
  - Final result is `128'h52525252_01010101_7d7d7d7d_ffffffff`.
  - Mid-block after 2 SUB cycles, the state register reads `128'h52525252_01010101_ffffffff_16161616`.
- Back-pressure: hold `out_ready=0` for 10 cycles after `out_valid` rises:
  - `out_data` is stable.
  - `in_ready=0` while `in_valid=1`.
  - Release `out_ready` while offering the next block: the handshake completes and the next block is in SUB on the following cycle with no IDLE cycle.
- Streaming 8 random blocks with `out_ready=1`:
  - Outputs match a per-byte inverse S-box reference model, in order.
  - 1 block per 5 cycles for `COLS_PER_BEAT=1`, and 1 block per 2 cycles for `COLS_PER_BEAT=4`.
- Flush during the 2nd SUB cycle:
  - Next cycle is IDLE with `out_valid=0` and no output for the aborted block.
  - A following block completes correctly.
  - Repeat the flush in DONE with `out_ready=1`: no output handshake is counted.
- Assert `rst_n` low asynchronously mid-SUB:
  - All outputs reach their reset values before the next clock edge.
  - After release, a new block processes normally.
